// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundle of the signals between the pipeline datapath and the hazard
//   sequencing controller.
//   master : datapath side; drives the ID/EX decode fields, samples the
//            stall/flush/select controls.
//   slave  : controller side (hazard_ctrl).
//   Optional macro HAZARD_STATS_EN adds the stall_cycles / flush_count
//   statistics outputs.
//
//   Signals
//     id_rs, id_rt        ID source registers
//     id_uses_rs/_rt      ID instruction actually reads rs / rt
//     ex_rd               EX destination register
//     ex_mem_read         EX instruction is a load
//     ex_is_branch        EX instruction is a conditional branch
//     ex_zero             branch condition true
//     ex_md_start         first EX cycle of a mult/div
//     ex_md_div           1 = divide, 0 = multiply
//     pc_stall            hold PC
//     if_id_stall         hold IF/ID
//     if_id_flush         clear IF/ID to NOP
//     id_ex_stall         hold ID/EX
//     id_ex_bubble        load NOP into ID/EX
//     pc_sel_branch       next PC from branch target
//     md_busy             multi-cycle op in progress
//     md_done             last EX cycle of mult/div
//     stall_cycles        (stats) cycles with pc_stall high, saturating
//     flush_count         (stats) cycles with if_id_flush high, saturating
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_is_branch;
  logic        ex_zero;
  logic        ex_md_start;
  logic        ex_md_div;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_bubble;
  logic        pc_sel_branch;
  logic        md_busy;
  logic        md_done;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
           ex_is_branch, ex_zero, ex_md_start, ex_md_div,
`ifdef HAZARD_STATS_EN
    input  stall_cycles, flush_count,
`endif
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           pc_sel_branch, md_busy, md_done
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
           ex_is_branch, ex_zero, ex_md_start, ex_md_div,
`ifdef HAZARD_STATS_EN
    output stall_cycles, flush_count,
`endif
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           pc_sel_branch, md_busy, md_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   EX-stage pipeline sequencing controller: load-use interlock, branch
//   squash, and hold of the pipeline while a multi-cycle mult/div occupies EX.
//   Optional macro HAZARD_STATS_EN adds saturating stall/flush counters.
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    hazard_ctrl_if.slave (decode fields in, pipeline controls out)
//
//   Parameters
//     MUL_CYCLES  EX cycles occupied by a multiply (2..65)
//     DIV_CYCLES  EX cycles occupied by a divide   (2..65)
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_RUN     | normal flow; branch / md start / load-use evaluated
//   ST_MD_BUSY | mult/div holding EX; cnt_q counts down to the done cycle
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  if (MUL_CYCLES < 2 || MUL_CYCLES > 65) begin : g_bad_mul
    $error("hazard_ctrl: MUL_CYCLES out of range");
  end
  if (DIV_CYCLES < 2 || DIV_CYCLES > 65) begin : g_bad_div
    $error("hazard_ctrl: DIV_CYCLES out of range");
  end

  // The start cycle itself and the done cycle both count toward occupancy,
  // so the counter is loaded with N-2 and the done cycle is cnt_q==0.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        load_use;
  logic        branch_taken;

  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_bubble;
  logic        pc_sel_branch;
  logic        md_busy;
  logic        md_done;

  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                     (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

  assign branch_taken = bus.ex_is_branch && bus.ex_zero;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    pc_sel_branch = 1'b0;
    md_busy       = 1'b0;
    md_done       = 1'b0;

    // Controls stay quiet while reset is asserted so a held md_start
    // cannot leak stalls or a busy indication out of reset.
    if (rst_n) begin
      unique case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
          end else if (bus.ex_md_start) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            md_busy     = 1'b1;
            state_d     = ST_MD_BUSY;
            cnt_d       = bus.ex_md_div ? DIV_LOAD : MUL_LOAD;
          end else if (load_use) begin
            // One cycle suffices: next cycle the load sits in MEM.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          md_busy = 1'b1;
          if (cnt_q != 6'd0) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            cnt_d       = cnt_q - 6'd1;
          end else begin
            // Last EX cycle: release the stalls so the pipeline advances
            // at this edge.
            md_done = 1'b1;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_stall      = pc_stall;
  assign bus.if_id_stall   = if_id_stall;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_stall   = id_ex_stall;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.pc_sel_branch = pc_sel_branch;
  assign bus.md_busy       = md_busy;
  assign bus.md_done       = md_done;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (if_id_flush && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed then random
// stimulus after each rising edge and queues the reference model's expected
// controls; a monitor pops and compares on each falling edge.
module tb_hazard_ctrl;
  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_bubble;
    logic pc_sel_branch;
    logic md_busy;
    logic md_done;
  } outs_t;

  logic clk;
  logic rst_n;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  outs_t exp_q[$];
`ifdef HAZARD_STATS_EN
  logic [31:0] exp_stall_q[$];
  logic [15:0] exp_flush_q[$];
  logic [31:0] m_stall;
  logic [15:0] m_flush;
`endif

  int n_checks;
  int n_pass;
  int cyc;

  // Reference state: number of EX cycles still owed to a running mult/div
  // after the current one (0 = no multi-cycle op in flight).
  int md_left;

  task automatic drive(input logic rn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic mr, input logic br, input logic z,
                       input logic st, input logic dv);
    outs_t e;
    logic lu;
    @(posedge clk);
    #1;
    rst_n            = rn;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_uses_rs   = urs;
    bus.id_uses_rt   = urt;
    bus.ex_rd        = rd;
    bus.ex_mem_read  = mr;
    bus.ex_is_branch = br;
    bus.ex_zero      = z;
    bus.ex_md_start  = st;
    bus.ex_md_div    = dv;

    lu = mr && (rd != 5'd0) && ((urs && rs == rd) || (urt && rt == rd));
    e  = '0;
    if (!rn) begin
      md_left = 0;
    end else if (md_left > 0) begin
      e.md_busy = 1'b1;
      if (md_left == 1) begin
        e.md_done = 1'b1;
      end else begin
        e.pc_stall = 1'b1; e.if_id_stall = 1'b1; e.id_ex_stall = 1'b1;
      end
      md_left--;
    end else if (br && z) begin
      e.pc_sel_branch = 1'b1; e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1;
    end else if (st) begin
      e.pc_stall = 1'b1; e.if_id_stall = 1'b1; e.id_ex_stall = 1'b1;
      e.md_busy = 1'b1;
      md_left = (dv ? DIV_N : MUL_N) - 1;
    end else if (lu) begin
      e.pc_stall = 1'b1; e.if_id_stall = 1'b1; e.id_ex_bubble = 1'b1;
    end
    exp_q.push_back(e);
`ifdef HAZARD_STATS_EN
    exp_stall_q.push_back(m_stall);
    exp_flush_q.push_back(m_flush);
    if (!rn) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (e.pc_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (e.if_id_flush && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: combinational controls are stable mid-cycle.
  initial begin
    outs_t e;
    outs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
             bus.id_ex_bubble, bus.pc_sel_branch, bus.md_busy, bus.md_done};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL controls cycle %0d: got %b want %b (pcs,ifs,iff,ids,bub,sel,busy,done)",
                      cyc, a, e);
`ifdef HAZARD_STATS_EN
        begin
          logic [31:0] es;
          logic [15:0] ef;
          es = exp_stall_q.pop_front();
          ef = exp_flush_q.pop_front();
          n_checks++;
          if (bus.stall_cycles === es) n_pass++;
          else $display("FAIL stall_cycles cycle %0d: got %0d want %0d", cyc, bus.stall_cycles, es);
          n_checks++;
          if (bus.flush_count === ef) n_pass++;
          else $display("FAIL flush_count cycle %0d: got %0d want %0d", cyc, bus.flush_count, ef);
        end
`endif
        cyc++;
      end
    end
  end

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; md_left = 0;
`ifdef HAZARD_STATS_EN
    m_stall = '0; m_flush = '0;
`endif
    rst_n = 1'b0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.ex_rd = '0; bus.ex_mem_read = 0; bus.ex_is_branch = 0; bus.ex_zero = 0;
    bus.ex_md_start = 0; bus.ex_md_div = 0;

    // Reset held with md_start asserted: nothing may start.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Load-use on rs, on rt, and the ex_rd==0 exception.
    drive(1, 8, 0, 1, 0, 8, 1, 0, 0, 0, 0);
    idle(1);
    drive(1, 3, 9, 0, 1, 9, 1, 0, 0, 0, 0);
    drive(1, 9, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    idle(1);

    // Taken branch overriding load-use; untaken branch.
    drive(1, 8, 0, 1, 0, 8, 1, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);

    // Multiply: EX held stable for its occupancy.
    for (int i = 0; i < MUL_N; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Full divide.
    for (int i = 0; i < DIV_N; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);

    // Divide interrupted by reset at its 10th cycle.
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);

    // Stats scenario from a fresh reset: load-use, mult, taken branch.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    for (int i = 0; i < MUL_N; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(2);

    // Randomized traffic; small register range makes matches frequent.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 59) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d entries left want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
